// File: rtl/dump_pkg.sv
// Shared types and constants for the ROM-to-UART dump controller.
package dump_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int ACK_TIMEOUT    = 4;

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, SEND, WAIT_ACK, WAIT_TX, GAP, NEXT
    } state_t;
endpackage

// File: rtl/dump_byte_sender.sv
// Hands one byte at a time to the UART using its senddata/txdone handshake.
// When 'more' is set at byte completion it chains straight into the next send.
module dump_byte_sender
    import dump_pkg::*;
#(
    parameter int GAP_CYC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       more,
    input  logic [7:0] byte_in,
    input  logic       tx_done,
    output logic [7:0] tx_byte,
    output logic       tx_send,
    output logic       byte_done
);
    localparam logic [1:0]  ACK_LAST = 2'(ACK_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t      state, nxt;
    logic [1:0]  ack_cnt;
    logic [15:0] gap_cnt;

    always_comb begin
        nxt       = state;
        byte_done = 1'b0;
        case (state)
            IDLE:     if (go) nxt = SEND;
            SEND:     if (tx_done) nxt = WAIT_ACK;
            // Late-deasserting transmitters: accept after a bounded wait.
            WAIT_ACK: if (!tx_done || ack_cnt == ACK_LAST) nxt = WAIT_TX;
            WAIT_TX: begin
                if (tx_done) begin
                    if (GAP_CYC > 0) begin
                        nxt = GAP;
                    end else begin
                        byte_done = 1'b1;
                        nxt       = more ? SEND : IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    byte_done = 1'b1;
                    nxt       = more ? SEND : IDLE;
                end
            end
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_send <= 1'b0;
            tx_byte <= 8'h00;
            ack_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= nxt;
            tx_send <= (state == SEND) && tx_done;
            if (state == SEND && tx_done) tx_byte <= byte_in;
            ack_cnt <= (state == WAIT_ACK) ? ack_cnt + 2'd1 : 2'd0;
            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
        end
    end
endmodule

// File: rtl/rom_dump_ctrl.sv
// Dumps num_words ROM words starting at base_addr over the UART, LSB byte first.
module rom_dump_ctrl
    import dump_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int RD_LAT  = 1,
    parameter int GAP_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd,
    output logic [7:0]        tx_byte,
    output logic              tx_send,
    input  logic              tx_done
);
    localparam logic [1:0]    LAT_LAST  = 2'(RD_LAT - 1);
    localparam logic [1:0]    IDX_LAST  = 2'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state, nxt;
    logic [ADDR_W:0] remaining;
    logic [1:0]      lat_cnt;
    logic [1:0]      byte_idx;
    logic [31:0]     shreg;
    logic            go, more, byte_done, accept;

    // start is ignored in the cycle a done pulse is still showing
    assign accept = (state == IDLE) && start && !done;
    assign go     = (state == LOAD);
    assign more   = (byte_idx != IDX_LAST);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (accept) nxt = (num_words == '0) ? NEXT : FETCH;
            FETCH: if (lat_cnt == LAT_LAST) nxt = LOAD;
            LOAD:  nxt = SEND;
            SEND:  if (byte_done && !more) nxt = NEXT;
            NEXT:  nxt = (remaining <= ONE) ? IDLE : FETCH;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
        end else begin
            state <= nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_addr  <= base_addr;
                        remaining <= num_words;
                        busy      <= 1'b1;
                    end
                end
                FETCH: lat_cnt <= (lat_cnt == LAT_LAST) ? 2'd0 : lat_cnt + 2'd1;
                LOAD: begin
                    shreg    <= mem_rd;
                    byte_idx <= '0;
                end
                SEND: begin
                    if (byte_done) begin
                        shreg    <= shreg >> 8;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                NEXT: begin
                    mem_addr <= mem_addr + 1'b1;
                    if (remaining != '0) remaining <= remaining - ONE;
                    if (remaining <= ONE) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    dump_byte_sender #(.GAP_CYC(GAP_CYC)) u_sender (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .more      (more),
        .byte_in   (shreg[7:0]),
        .tx_done   (tx_done),
        .tx_byte   (tx_byte),
        .tx_send   (tx_send),
        .byte_done (byte_done)
    );
endmodule

// File: tb/tb_rom_dump_ctrl.sv
// Directed bench: dut0 uses RD_LAT=1/GAP=0, dut1 uses RD_LAT=3/GAP=5.
module tb_rom_dump_ctrl;
    localparam int AW = 13;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic          rst;
    logic          start [2];
    logic [AW-1:0] base  [2];
    logic [AW:0]   num   [2];
    logic          busy [2], done [2], tx_send [2], tx_done [2];
    logic [AW-1:0] maddr [2];
    logic [31:0]   mrd   [2];
    logic [7:0]    txb   [2];

    int nvec = 0;
    int nerr = 0;

    rom_dump_ctrl #(.ADDR_W(AW), .RD_LAT(1), .GAP_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .base_addr(base[0]), .num_words(num[0]),
        .busy(busy[0]), .done(done[0]), .mem_addr(maddr[0]), .mem_rd(mrd[0]),
        .tx_byte(txb[0]), .tx_send(tx_send[0]), .tx_done(tx_done[0]));

    rom_dump_ctrl #(.ADDR_W(AW), .RD_LAT(3), .GAP_CYC(5)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .base_addr(base[1]), .num_words(num[1]),
        .busy(busy[1]), .done(done[1]), .mem_addr(maddr[1]), .mem_rd(mrd[1]),
        .tx_byte(txb[1]), .tx_send(tx_send[1]), .tx_done(tx_done[1]));

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        case (a)
            13'h0010: return 32'h44332211;
            13'h0011: return 32'h88776655;
            default:  return 32'hC0DE0000 | 32'(a);
        endcase
    endfunction

    // ROM: registered read pipeline RD_LAT deep
    logic [31:0] pipe0;
    logic [31:0] pipe1 [3];
    always @(posedge clk) begin
        pipe0    <= rom_word(maddr[0]);
        pipe1[0] <= rom_word(maddr[1]);
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign mrd[0] = pipe0;
    assign mrd[1] = pipe1[2];

    // UART: txdone low for 20 cycles after senddata; 'stuck' pins it high
    int   ucnt  [2] = '{0, 0};
    logic udone [2] = '{1'b1, 1'b1};
    bit   stuck = 1'b0;
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (tx_send[k]) begin
                ucnt[k]  <= 20;
                udone[k] <= 1'b0;
            end else if (ucnt[k] > 1) begin
                ucnt[k] <= ucnt[k] - 1;
            end else if (ucnt[k] == 1) begin
                ucnt[k]  <= 0;
                udone[k] <= 1'b1;
            end
        end
    end
    assign tx_done[0] = udone[0] | stuck;
    assign tx_done[1] = udone[1];

    // Monitor
    int            cyc = 0;
    logic [7:0]    bq0 [$], bq1 [$];
    int            sc0 [$], dq0 [$], dq1 [$];
    logic [AW-1:0] aq0 [$];
    int            dcnt [2] = '{0, 0};
    int            last_rise [2] = '{-1000, -1000};
    logic          pdone [2] = '{1'b1, 1'b1};
    logic          pbusy0 = 1'b0;
    logic [AW-1:0] paddr0 = '0;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (tx_done[k] && !pdone[k]) last_rise[k] = cyc;
            pdone[k] = tx_done[k];
            if (tx_send[k]) begin
                if (k == 0) begin
                    bq0.push_back(txb[0]); sc0.push_back(cyc); dq0.push_back(cyc - last_rise[0]);
                end else begin
                    bq1.push_back(txb[1]); dq1.push_back(cyc - last_rise[1]);
                end
            end
            if (done[k]) dcnt[k]++;
        end
        if (busy[0] && (!pbusy0 || maddr[0] != paddr0)) aq0.push_back(maddr[0]);
        pbusy0 = busy[0];
        paddr0 = maddr[0];
    end

    task automatic clear_logs();
        bq0.delete(); bq1.delete(); sc0.delete(); dq0.delete(); dq1.delete(); aq0.delete();
        dcnt[0] = 0; dcnt[1] = 0;
    endtask

    task automatic pulse_start(input int k, input logic [AW-1:0] b, input logic [AW:0] n);
        @(negedge clk);
        base[k] = b; num[k] = n; start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int i;
        for (i = 0; i < budget && dcnt[k] == 0; i++) @(posedge clk);
        if (dcnt[k] == 0) begin
            nvec++; nerr++;
            $display("FAIL wait_done dut%0d: no done within %0d cycles", k, budget);
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic wait_tx_idle(input int k);
        int i;
        for (i = 0; i < 100 && !tx_done[k]; i++) @(posedge clk);
        nvec++;
        if (tx_done[k] !== 1'b1) begin
            nerr++; $display("FAIL tx_idle dut%0d: tx_done=%b want 1", k, tx_done[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            nvec += 5;
            if (busy[k] !== 1'b0)    begin nerr++; $display("FAIL reset_busy dut%0d: %b want 0", k, busy[k]); end
            if (done[k] !== 1'b0)    begin nerr++; $display("FAIL reset_done dut%0d: %b want 0", k, done[k]); end
            if (tx_send[k] !== 1'b0) begin nerr++; $display("FAIL reset_send dut%0d: %b want 0", k, tx_send[k]); end
            if (txb[k] !== 8'h00)    begin nerr++; $display("FAIL reset_byte dut%0d: %h want 00", k, txb[k]); end
            if (maddr[k] !== '0)     begin nerr++; $display("FAIL reset_addr dut%0d: %h want 0", k, maddr[k]); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Two-word dump with a second start injected while busy
    task automatic test_dump();
        logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        int i;
        clear_logs();
        pulse_start(0, 13'h0010, 14'd2);
        for (i = 0; i < 1000 && bq0.size() < 3; i++) @(posedge clk);
        pulse_start(0, 13'h0000, 14'd5);
        wait_done(0, 2000);
        repeat (40) @(posedge clk);
        nvec++;
        if (bq0.size() != 8) begin nerr++; $display("FAIL dump_count: %0d sends want 8", bq0.size()); end
        for (int j = 0; j < 8 && j < bq0.size(); j++) begin
            nvec++;
            if (bq0[j] !== exp[j]) begin nerr++; $display("FAIL dump_byte%0d: %h want %h", j, bq0[j], exp[j]); end
        end
        for (int j = 1; j < dq0.size(); j++) begin
            if (j % 4 != 0) begin
                nvec++;
                if (dq0[j] != 2) begin nerr++; $display("FAIL dump_spacing%0d: %0d want 2", j, dq0[j]); end
            end
        end
        nvec += 2;
        if (dcnt[0] != 1)     begin nerr++; $display("FAIL dump_done: %0d pulses want 1", dcnt[0]); end
        if (busy[0] !== 1'b0) begin nerr++; $display("FAIL dump_busy: %b want 0", busy[0]); end
    endtask

    task automatic test_zero();
        bit got = 1'b0;
        clear_logs();
        pulse_start(0, 13'h0123, 14'd0);
        for (int i = 0; i < 3 && !got; i++) begin
            @(posedge clk); #1;
            if (done[0]) got = 1'b1;
        end
        repeat (10) @(posedge clk);
        nvec += 4;
        if (!got)             begin nerr++; $display("FAIL zero_done: none within 3 cycles"); end
        if (dcnt[0] != 1)     begin nerr++; $display("FAIL zero_done_cnt: %0d want 1", dcnt[0]); end
        if (bq0.size() != 0)  begin nerr++; $display("FAIL zero_sends: %0d want 0", bq0.size()); end
        if (busy[0] !== 1'b0) begin nerr++; $display("FAIL zero_busy: %b want 0", busy[0]); end
    endtask

    task automatic test_wrap();
        logic [31:0] w [2];
        w[0] = rom_word(13'h1FFF);
        w[1] = rom_word(13'h0000);
        clear_logs();
        pulse_start(0, 13'h1FFF, 14'd2);
        wait_done(0, 2000);
        nvec += 2;
        if (aq0.size() != 2) begin nerr++; $display("FAIL wrap_addr_cnt: %0d want 2", aq0.size()); end
        else if (aq0[0] !== 13'h1FFF || aq0[1] !== 13'h0000) begin
            nerr++; $display("FAIL wrap_addr_seq: %h,%h want 1fff,0000", aq0[0], aq0[1]);
        end
        if (bq0.size() != 8) begin nerr++; $display("FAIL wrap_count: %0d want 8", bq0.size()); end
        for (int j = 0; j < 8 && j < bq0.size(); j++) begin
            nvec++;
            if (bq0[j] !== 8'(w[j/4] >> (8 * (j % 4)))) begin
                nerr++; $display("FAIL wrap_byte%0d: %h want %h", j, bq0[j], 8'(w[j/4] >> (8 * (j % 4))));
            end
        end
        wait_tx_idle(0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [4] = '{8'h20, 8'h00, 8'hDE, 8'hC0};
        int i;
        clear_logs();
        pulse_start(0, 13'h0010, 14'd2);
        for (i = 0; i < 1000 && bq0.size() < 2; i++) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        nvec += 2;
        if (busy[0] !== 1'b0)    begin nerr++; $display("FAIL rstmid_busy: %b want 0", busy[0]); end
        if (tx_send[0] !== 1'b0) begin nerr++; $display("FAIL rstmid_send: %b want 0", tx_send[0]); end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        nvec += 2;
        if (dcnt[0] != 0)    begin nerr++; $display("FAIL rstmid_nodone: %0d pulses want 0", dcnt[0]); end
        if (bq0.size() != 2) begin nerr++; $display("FAIL rstmid_sends: %0d want 2", bq0.size()); end
        wait_tx_idle(0);
        clear_logs();
        pulse_start(0, 13'h0020, 14'd1);
        wait_done(0, 1000);
        nvec++;
        if (bq0.size() != 4) begin nerr++; $display("FAIL redump_count: %0d want 4", bq0.size()); end
        for (int j = 0; j < 4 && j < bq0.size(); j++) begin
            nvec++;
            if (bq0[j] !== exp[j]) begin nerr++; $display("FAIL redump_byte%0d: %h want %h", j, bq0[j], exp[j]); end
        end
        wait_tx_idle(0);
    endtask

    // tx_done never drops: each byte advances on the ack timeout
    task automatic test_timeout();
        logic [31:0] w [2];
        w[0] = rom_word(13'h0030);
        w[1] = rom_word(13'h0031);
        clear_logs();
        stuck = 1'b1;
        pulse_start(0, 13'h0030, 14'd2);
        wait_done(0, 500);
        nvec += 2;
        if (bq0.size() != 8) begin nerr++; $display("FAIL tmo_count: %0d want 8", bq0.size()); end
        if (dcnt[0] != 1)    begin nerr++; $display("FAIL tmo_done: %0d want 1", dcnt[0]); end
        for (int j = 0; j < 8 && j < bq0.size(); j++) begin
            nvec++;
            if (bq0[j] !== 8'(w[j/4] >> (8 * (j % 4)))) begin
                nerr++; $display("FAIL tmo_byte%0d: %h want %h", j, bq0[j], 8'(w[j/4] >> (8 * (j % 4))));
            end
            if (j % 4 != 0) begin
                nvec++;
                if (sc0[j] - sc0[j-1] != 6) begin
                    nerr++; $display("FAIL tmo_interval%0d: %0d want 6", j, sc0[j] - sc0[j-1]);
                end
            end
        end
        stuck = 1'b0;
        wait_tx_idle(0);
    endtask

    task automatic test_lat_gap();
        logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        clear_logs();
        pulse_start(1, 13'h0010, 14'd2);
        wait_done(1, 3000);
        nvec += 2;
        if (bq1.size() != 8) begin nerr++; $display("FAIL gap_count: %0d want 8", bq1.size()); end
        if (dcnt[1] != 1)    begin nerr++; $display("FAIL gap_done: %0d want 1", dcnt[1]); end
        for (int j = 0; j < 8 && j < bq1.size(); j++) begin
            nvec++;
            if (bq1[j] !== exp[j]) begin nerr++; $display("FAIL gap_byte%0d: %h want %h", j, bq1[j], exp[j]); end
            if (j % 4 != 0) begin
                nvec++;
                if (dq1[j] != 7) begin nerr++; $display("FAIL gap_spacing%0d: %0d want 7", j, dq1[j]); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; base[k] = '0; num[k] = '0;
        end
        test_reset();
        test_dump();
        test_zero();
        test_wrap();
        test_reset_mid();
        test_timeout();
        test_lat_gap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
